host_cmd_bridge: RTL and testbench
==================================

Name: host_cmd_bridge

Overview:
- Upstream feeder for the control top-level's MMIO host port.
- Accepts host read/write requests on a valid/ready stream and buffers them in a request FIFO.
- Serialises each request onto host_addr / host_wr_data / host_wr_en, one at a time.
- Captures host_rd_data for reads and returns it on a valid/ready response channel, in strict request order.

Parameters:
ADDR_W, `MMIO_ADDR_WIDTH, width of MMIO address
DATA_W, `HOST_DATA_WIDTH, width of MMIO data
FIFO_DEPTH, 4, request FIFO entries; power of 2, >= 2
RD_LATENCY, 1, cycles from host_addr presentation to host_rd_data valid; legal 0..3

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  1  request present
req_ready  output  1  bridge can accept a request this cycle
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  MMIO address
req_wdata  input  DATA_W  write data; ignored for reads
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer takes read data
rsp_rdata  output  DATA_W  read data
host_addr  output  ADDR_W  to control top-level host_addr
host_wr_data  output  DATA_W  to control top-level host_wr_data
host_wr_en  output  1  to control top-level host_wr_en; single-cycle pulse per write
host_rd_data  input  DATA_W  from control top-level host_rd_data
fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
busy  output  1  FIFO non-empty, or FSM not IDLE, or rsp_valid

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FIFO emptied; FSM to IDLE.
  - host_addr=0, host_wr_data=0, host_wr_en=0.
  - rsp_valid=0, rsp_rdata=0, fifo_count=0.
  - Mid-operation reset discards queued requests and any in-flight read; no write is re-issued after reset.
- Request FIFO:
  - req_ready = !full, registered-state derived, with no combinational path from rsp_ready or FSM pop.
  - Push when req_valid && req_ready.
  - Pop and push in the same cycle are both honoured; fifo_count is unchanged.
  - No bypass: an entry is visible to the FSM the cycle after the push.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by occupancy count.
- FSM states: IDLE, ISSUE, RD_WAIT, RSP.
  - IDLE: if FIFO non-empty and rsp_valid=0, pop the head and register host_addr = entry addr. For a write, also register host_wr_data = entry data and host_wr_en=1. Go to ISSUE.
  - ISSUE, write: host_wr_en drops to 0 next cycle; return to IDLE.
  - ISSUE, read: host_wr_en stays 0. If RD_LATENCY=0, capture host_rd_data into rsp_rdata, set rsp_valid, go to RSP. Otherwise go to RD_WAIT with wait counter = RD_LATENCY.
  - RD_WAIT: decrement the counter each cycle. At 0, capture host_rd_data, set rsp_valid, go to RSP.
  - RSP: hold rsp_valid and rsp_rdata stable until rsp_ready. On the handshake, clear rsp_valid and go to IDLE.
- Issue and hold rules:
  - host_addr holds its last value whenever no request is issuing; it is stable for the full read latency window.
  - host_wr_data changes only on a write issue.
  - host_wr_en is never high for two consecutive cycles.
  - At most one request is in flight. No write issues while a read response is pending, so ordering is strict.
- Latency, for an empty bridge with a request accepted in cycle T:
  - host_wr_en or read host_addr is valid in cycle T+2.
  - rsp_valid first rises in cycle T+3+RD_LATENCY.
  - Back-to-back writes reach host_wr_en at most one every 2 cycles.

Test Plan:
- Reset then single write addr=0x04 data=0xA5 -> host_wr_en high exactly one cycle at T+2 with host_addr=0x04, host_wr_data=0xA5; no rsp_valid.
- Read addr=0x08 with RD_LATENCY=1, host_rd_data model returning 0x3C -> rsp_valid at T+4, rsp_rdata=0x3C. With rsp_ready held 0 for 5 cycles, value is held, and a queued write behind the read does not pulse host_wr_en until the response handshake.
- Push 5 writes back-to-back with FIFO_DEPTH=4 while the bridge is stalled behind an unconsumed read -> req_ready=0 with fifo_count=4; 5th accepted only after a pop; all writes appear in order.
- Simultaneous push and pop at fifo_count=2 -> fifo_count stays 2; pointers wrap after 4+ entries with correct data (addresses 0x00..0x1C).
- Mixed sequence W(0x00,0x11), R(0x04), W(0x08,0x22), R(0x0C) with rsp_ready=1 -> strict order on host port; two responses in order; busy drops to 0 after the last handshake.
- Assert rst_n=0 for one cycle during RD_WAIT with 3 queued requests -> next cycle: fifo_count=0, rsp_valid=0, host_wr_en=0, host_addr=0, busy=0; no further host activity.

Source files
------------

// File: rtl/host_cmd_bridge.sv
// ============================================================================
// host_cmd_bridge
// ----------------------------------------------------------------------------
// Upstream feeder for the control top-level's MMIO host port. Host read/write
// requests arrive on a valid/ready stream and are queued in a small request
// FIFO. Requests are issued one at a time onto host_addr / host_wr_data /
// host_wr_en. For reads, host_rd_data is captured after RD_LATENCY cycles and
// returned on a valid/ready response channel. At most one request is in
// flight, so responses always come back in request order.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   req_valid     request present
//   req_ready     bridge can accept a request (FIFO not full)
//   req_write     1 = write, 0 = read
//   req_addr      MMIO address
//   req_wdata     write data (ignored for reads)
//   rsp_valid     read data available
//   rsp_ready     consumer takes read data
//   rsp_rdata     read data
//   host_addr     to control top-level host_addr
//   host_wr_data  to control top-level host_wr_data
//   host_wr_en    to control top-level host_wr_en (one-cycle pulse per write)
//   host_rd_data  from control top-level host_rd_data
//   fifo_count    current request FIFO occupancy
//   busy          FIFO non-empty, or a request in progress, or rsp_valid
// ============================================================================

`timescale 1ns/1ps

`ifndef MMIO_ADDR_WIDTH
`define MMIO_ADDR_WIDTH 8
`endif
`ifndef HOST_DATA_WIDTH
`define HOST_DATA_WIDTH 8
`endif

module host_cmd_bridge #(
    parameter int ADDR_W     = `MMIO_ADDR_WIDTH,
    parameter int DATA_W     = `HOST_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [DATA_W-1:0]                 req_wdata,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_W-1:0]                 rsp_rdata,
    output logic [ADDR_W-1:0]                 host_addr,
    output logic [DATA_W-1:0]                 host_wr_data,
    output logic                              host_wr_en,
    input  logic [DATA_W-1:0]                 host_rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    // The first RD_WAIT cycle already counts as one cycle of latency, so the
    // counter is loaded with RD_LATENCY-1 and data is captured when it hits 0.
    localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        RSP
    } state_t;

    state_t state;

    logic              mem_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data  [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              cur_write;
    logic [1:0]        wait_cnt;

    // req_ready depends only on the registered occupancy, so a pop in the
    // same cycle never feeds back into the upstream handshake.
    assign req_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push       = req_valid && req_ready;
    assign pop        = (state == IDLE) && (fifo_count != '0) && !rsp_valid;

    assign head_write = mem_write[rd_ptr];
    assign head_addr  = mem_addr[rd_ptr];
    assign head_data  = mem_data[rd_ptr];

    assign busy       = (fifo_count != '0) || (state != IDLE) || rsp_valid;

    // FIFO pointers and occupancy. Depth is a power of two so the pointers
    // wrap naturally; full and empty are told apart by the count.
    always_ff @(posedge clk) begin : fifo_ctrl
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage needs no reset; stale entries are never read because the
    // occupancy count gates every pop.
    always_ff @(posedge clk) begin : fifo_store
        if (push) begin
            mem_write[wr_ptr] <= req_write;
            mem_addr[wr_ptr]  <= req_addr;
            mem_data[wr_ptr]  <= req_wdata;
        end
    end

    // Issue sequencer: pops one request at a time, drives the host port and,
    // for reads, waits out the read latency before presenting the response.
    // A new request is only popped once any pending response has been taken,
    // which keeps writes from overtaking an unconsumed read.
    always_ff @(posedge clk) begin : issue_fsm
        if (!rst_n) begin
            state        <= IDLE;
            host_addr    <= '0;
            host_wr_data <= '0;
            host_wr_en   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            wait_cnt     <= 2'd0;
            cur_write    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        host_addr <= head_addr;
                        cur_write <= head_write;
                        if (head_write) begin
                            host_wr_data <= head_data;
                            host_wr_en   <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    host_wr_en <= 1'b0;
                    if (cur_write) begin
                        state <= IDLE;
                    end else if (RD_LATENCY == 0) begin
                        rsp_rdata <= host_rd_data;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        rsp_rdata <= host_rd_data;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_cmd_bridge.sv
// ============================================================================
// tb_host_cmd_bridge
// ----------------------------------------------------------------------------
// Self-checking bench for host_cmd_bridge. The host side is modelled as a
// read port returning (addr ^ 0x34) with RD_LATENCY cycles of delay. A
// scoreboard keeps every accepted request in arrival order; each host write
// pulse and each response handshake must match the oldest outstanding
// request. Directed scenarios additionally check cycle-exact timing.
// ============================================================================

`timescale 1ns/1ps

module tb_host_cmd_bridge;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int RD_LATENCY = 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH+1);
    localparam int PIPE_IDX   = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_ready = 1'b0;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_wr_en;
    logic [DATA_W-1:0] host_rd_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    req_t              exp_q[$];
    int                rsp_seen = 0;
    logic              prev_wr_en = 1'b0;
    logic              prev_rsp_valid = 1'b0;
    logic              prev_rsp_ready = 1'b0;
    logic [DATA_W-1:0] prev_wr_data = '0;
    logic [DATA_W-1:0] prev_rdata = '0;
    logic [DATA_W-1:0] rd_pipe [4];

    always #5 clk = ~clk;

    host_cmd_bridge #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .host_addr   (host_addr),
        .host_wr_data(host_wr_data),
        .host_wr_en  (host_wr_en),
        .host_rd_data(host_rd_data),
        .fifo_count  (fifo_count),
        .busy        (busy)
    );

    function automatic logic [DATA_W-1:0] rd_value(input logic [ADDR_W-1:0] a);
        return a ^ 8'h34;
    endfunction

    // Host read port: data for an address appears RD_LATENCY cycles after the
    // address, and is unrelated garbage-from-the-past before that.
    always @(posedge clk) begin
        rd_pipe[0] <= rd_value(host_addr);
        for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign host_rd_data = (RD_LATENCY == 0) ? rd_value(host_addr) : rd_pipe[PIPE_IDX];

    // Scoreboard step, evaluated mid-cycle when inputs and outputs are both
    // settled for the coming rising edge.
    task automatic scoreboard_step();
        req_t h;
        if (!rst_n) begin
            exp_q.delete();
            prev_wr_en     = 1'b0;
            prev_rsp_valid = 1'b0;
            prev_rsp_ready = 1'b0;
            prev_wr_data   = '0;
            prev_rdata     = '0;
            return;
        end
        if (host_wr_en) begin
            n_checks++;
            if (prev_wr_en !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL wr_en_pulse: host_wr_en high in consecutive cycles, got 1 want 0 on previous cycle");
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL host_write: got write addr=%h data=%h, want no host activity", host_addr, host_wr_data);
            end else begin
                h = exp_q.pop_front();
                if (!h.write || host_addr !== h.addr || host_wr_data !== h.data) begin
                    n_fail++;
                    $display("[TB] FAIL host_write: got write addr=%h data=%h, want %s addr=%h data=%h",
                             host_addr, host_wr_data, h.write ? "write" : "read", h.addr, h.data);
                end
            end
        end
        n_checks++;
        if (!host_wr_en && host_wr_data !== prev_wr_data) begin
            n_fail++;
            $display("[TB] FAIL wr_data_hold: got %h want %h", host_wr_data, prev_wr_data);
        end
        if (prev_rsp_valid && !prev_rsp_ready) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== prev_rdata) begin
                n_fail++;
                $display("[TB] FAIL rsp_hold: got valid=%b data=%h want valid=1 data=%h", rsp_valid, rsp_rdata, prev_rdata);
            end
        end
        if (rsp_valid && rsp_ready) begin
            rsp_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL response: got data=%h want no response", rsp_rdata);
            end else begin
                h = exp_q.pop_front();
                if (h.write || rsp_rdata !== rd_value(h.addr)) begin
                    n_fail++;
                    $display("[TB] FAIL response: got data=%h want %s addr=%h data=%h",
                             rsp_rdata, h.write ? "write" : "read", h.addr, rd_value(h.addr));
                end
            end
        end
        if (req_valid && req_ready) begin
            h.write = req_write;
            h.addr  = req_addr;
            h.data  = req_write ? req_wdata : '0;
            exp_q.push_back(h);
        end
        prev_wr_en     = host_wr_en;
        prev_wr_data   = host_wr_data;
        prev_rsp_valid = rsp_valid;
        prev_rsp_ready = rsp_ready;
        prev_rdata     = rsp_rdata;
    endtask

    // Advance one cycle; returns 2 time units after the rising edge.
    task automatic tick();
        @(negedge clk);
        scoreboard_step();
        @(posedge clk);
        #2;
    endtask

    // Hold a request until accepted or the cycle budget runs out. Returns in
    // the cycle after acceptance.
    task automatic push_req(input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input int max_wait, output bit ok);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid(input string name, input int max_wait);
        int i;
        for (i = 0; i < max_wait && rsp_valid !== 1'b1; i++) tick();
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s: rsp_valid got %b want 1 within %0d cycles", name, rsp_valid, max_wait);
        end
    endtask

    task automatic drain(input string name);
        int i;
        rsp_ready = 1'b1;
        for (i = 0; i < 60 && busy !== 1'b0; i++) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s_drain: busy got %b want 0", name, busy);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL %s_outstanding: got %0d unserved requests want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        n_checks++; if (host_addr !== '0) begin n_fail++; $display("[TB] FAIL reset_host_addr: got %h want 00", host_addr); end
        n_checks++; if (host_wr_data !== '0) begin n_fail++; $display("[TB] FAIL reset_wr_data: got %h want 00", host_wr_data); end
        n_checks++; if (host_wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_en: got %b want 0", host_wr_en); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== '0) begin n_fail++; $display("[TB] FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
        n_checks++; if (fifo_count !== '0) begin n_fail++; $display("[TB] FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_write();
        bit ok;
        push_req(1'b1, 8'h04, 8'hA5, 4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL sw_accept: got not accepted want accepted"); end
        n_checks++; if (host_wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_early: host_wr_en got %b want 0 at T+1", host_wr_en); end
        tick();
        n_checks++; if (host_wr_en !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_wr_en: got %b want 1 at T+2", host_wr_en); end
        n_checks++; if (host_addr !== 8'h04) begin n_fail++; $display("[TB] FAIL sw_addr: got %h want 04", host_addr); end
        n_checks++; if (host_wr_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL sw_data: got %h want a5", host_wr_data); end
        tick();
        n_checks++; if (host_wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_pulse: host_wr_en got %b want 0 at T+3", host_wr_en); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_no_rsp: rsp_valid got %b want 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_busy: got %b want 0", busy); end
    endtask

    task automatic test_read_stall();
        bit ok;
        rsp_ready = 1'b0;
        push_req(1'b0, 8'h08, 8'h00, 4, ok);
        push_req(1'b1, 8'h10, 8'h55, 4, ok);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_early2: rsp_valid got %b want 0 at T+2", rsp_valid); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_early3: rsp_valid got %b want 0 at T+3", rsp_valid); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_valid: rsp_valid got %b want 1 at T+4", rsp_valid); end
        n_checks++; if (rsp_rdata !== 8'h3C) begin n_fail++; $display("[TB] FAIL rd_data: got %h want 3c", rsp_rdata); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || host_wr_en !== 1'b0 || fifo_count !== CNT_W'(1)) begin
                n_fail++;
                $display("[TB] FAIL rd_stall: got valid=%b data=%h wr_en=%b count=%0d want 1/3c/0/1",
                         rsp_valid, rsp_rdata, host_wr_en, fifo_count);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || host_wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_release1: got valid=%b wr_en=%b want 0/0", rsp_valid, host_wr_en); end
        tick();
        n_checks++; if (host_wr_en !== 1'b1 || host_addr !== 8'h10) begin n_fail++; $display("[TB] FAIL rd_release2: got wr_en=%b addr=%h want 1/10", host_wr_en, host_addr); end
        drain("rd_stall");
    endtask

    task automatic test_fifo_full();
        bit ok;
        rsp_ready = 1'b0;
        push_req(1'b0, 8'h0C, 8'h00, 4, ok);
        wait_rsp_valid("full_stall", 10);
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 8'(8'h20 + 4*i), 8'($urandom), 2, ok);
            n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL full_push%0d: got not accepted want accepted", i); end
        end
        n_checks++; if (fifo_count !== CNT_W'(4)) begin n_fail++; $display("[TB] FAIL full_count: got %0d want 4", fifo_count); end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_wdata = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready: got %b want 0", req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (req_ready !== 1'b0 || fifo_count !== CNT_W'(4)) begin n_fail++; $display("[TB] FAIL full_prepop: got ready=%b count=%0d want 0/4", req_ready, fifo_count); end
        push_req(1'b1, 8'h30, req_wdata, 6, ok);
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL full_fifth: got not accepted want accepted after pop"); end
        drain("full");
    endtask

    task automatic test_push_pop_wrap();
        bit ok;
        rsp_ready = 1'b0;
        push_req(1'b0, 8'h38, 8'h00, 4, ok);
        wait_rsp_valid("pp_stall", 10);
        push_req(1'b1, 8'h40, 8'($urandom), 2, ok);
        push_req(1'b1, 8'h44, 8'($urandom), 2, ok);
        n_checks++; if (fifo_count !== CNT_W'(2)) begin n_fail++; $display("[TB] FAIL pp_setup: count got %0d want 2", fifo_count); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (fifo_count !== CNT_W'(2) || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL pp_before: got count=%0d valid=%b want 2/0", fifo_count, rsp_valid); end
        push_req(1'b1, 8'h48, 8'($urandom), 1, ok);
        n_checks++; if (fifo_count !== CNT_W'(2)) begin n_fail++; $display("[TB] FAIL pp_count: got %0d want 2", fifo_count); end
        n_checks++; if (host_wr_en !== 1'b1 || host_addr !== 8'h40) begin n_fail++; $display("[TB] FAIL pp_pop: got wr_en=%b addr=%h want 1/40", host_wr_en, host_addr); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_req(1'b1, 8'(4*i), 8'($urandom), 8, ok);
            n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL wrap_push%0d: got not accepted want accepted", i); end
        end
        drain("wrap");
    endtask

    task automatic test_mixed();
        bit ok;
        int start;
        rsp_ready = 1'b1;
        start = rsp_seen;
        push_req(1'b1, 8'h00, 8'h11, 6, ok);
        push_req(1'b0, 8'h04, 8'h00, 6, ok);
        push_req(1'b1, 8'h08, 8'h22, 6, ok);
        push_req(1'b0, 8'h0C, 8'h00, 6, ok);
        drain("mixed");
        n_checks++; if (rsp_seen - start != 2) begin n_fail++; $display("[TB] FAIL mixed_rsp_count: got %0d want 2", rsp_seen - start); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        rsp_ready = 1'b0;
        push_req(1'b0, 8'h50, 8'h00, 4, ok);
        wait_rsp_valid("rm_stall", 10);
        push_req(1'b0, 8'h54, 8'h00, 2, ok);
        push_req(1'b1, 8'h58, 8'($urandom), 2, ok);
        push_req(1'b1, 8'h5C, 8'($urandom), 2, ok);
        push_req(1'b1, 8'h60, 8'($urandom), 2, ok);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (fifo_count !== CNT_W'(3) || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_before: got count=%0d valid=%b want 3/0", fifo_count, rsp_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (fifo_count !== '0) begin n_fail++; $display("[TB] FAIL rm_count: got %0d want 0", fifo_count); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (host_wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_wr_en: got %b want 0", host_wr_en); end
        n_checks++; if (host_addr !== '0) begin n_fail++; $display("[TB] FAIL rm_addr: got %h want 00", host_addr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_busy: got %b want 0", busy); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (host_wr_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rm_quiet: got wr_en=%b valid=%b busy=%b want 0/0/0", host_wr_en, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        bit acc = 1'b0;
        req_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!req_valid || acc) begin
                req_valid = ($urandom_range(0, 2) != 0);
                req_write = 1'($urandom_range(0, 1));
                req_addr  = 8'($urandom);
                req_wdata = 8'($urandom);
            end
            acc = req_valid && req_ready;
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        req_valid = 1'b0;
        drain("random");
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation got stuck, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_stall();
        test_fifo_full();
        test_push_pop_wrap();
        test_mixed();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
